grid_claim_arbiter: RTL and testbench

GRID_CLAIM_ARBITER -- requirements
Module: grid_claim_arbiter

---
 rtl/placement_pkg.sv | 21 ++
 rtl/rr_picker.sv | 26 ++
 rtl/grid_claim_arbiter.sv | 131 +++++++++++++
 tb/tb_grid_claim_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/placement_pkg.sv
// Shared encodings for the grid placement engines: free-cell marker, engine
// operation codes and the claim arbiter's transaction state.
package placement_pkg;

  // Widest cell supported; users slice the low DATA_W bits.
  localparam logic [63:0] EMPTY_CELL = {64{1'b1}};

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_CLAIM = 1'b1
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/rr_picker.sv
// Round-robin requester picker: the first active request strictly after
// last_grant (wrapping) wins, so the previous winner goes to the back.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] grant,
  output logic             valid
);

  // Walk offsets from farthest to nearest so the nearest active request is
  // the last one written and therefore wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int i = N_REQ; i >= 1; i--) begin
      if (req[(int'(last_grant) + i) % N_REQ]) begin
        grant = IDX_W'((int'(last_grant) + i) % N_REQ);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/grid_claim_arbiter.sv
// Shares one registered-read grid RAM port between N_REQ placement engines,
// serialising READ and atomic CLAIM (test-and-set) transactions.
module grid_claim_arbiter
  import placement_pkg::*;
#(
  parameter int                N_REQ  = 4,
  parameter int                ADDR_W = 12,
  parameter int                DATA_W = 32,
  parameter logic [DATA_W-1:0] EMPTY  = EMPTY_CELL[DATA_W-1:0]
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         op,
  input  logic [N_REQ*ADDR_W-1:0]  addr,
  input  logic [N_REQ*DATA_W-1:0]  wdata,
  output logic [N_REQ-1:0]         ack,
  output logic [DATA_W-1:0]        rdata,
  output logic                     success,
  output logic                     mem_re,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_din,
  input  logic [DATA_W-1:0]        mem_dout,
  output logic                     busy,
  output logic [15:0]              fail_cnt
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e             state, state_nxt;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_vld;
  op_e                op_p0;
  logic [ADDR_W-1:0]  addr_p0;
  logic [DATA_W-1:0]  wdata_p0;
  logic [DATA_W-1:0]  rdata_p1;
  logic               success_p1;
  logic [15:0]        fail_cnt_q;
  logic               claim_ok;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req        (req),
    .last_grant (last_grant),
    .grant      (pick_idx),
    .valid      (pick_vld)
  );

  // A writing EMPTY would leave the cell looking free, so it never counts as a claim.
  assign claim_ok = (op_p0 == OP_CLAIM) && (mem_dout == EMPTY) && (wdata_p0 != EMPTY);

  always_comb begin
    state_nxt = state;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    ack       = '0;
    unique case (state)
      S_IDLE: begin
        if (pick_vld) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        mem_re    = 1'b1;
        mem_addr  = addr_p0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (claim_ok) begin
          mem_we   = 1'b1;
          mem_addr = addr_p0;
          mem_din  = wdata_p0;
        end
        state_nxt = S_RESP;
      end
      S_RESP: begin
        ack[last_grant] = 1'b1;
        state_nxt       = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Grant (p0): control state and per-transaction results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= IDX_W'(N_REQ - 1);
      op_p0      <= OP_READ;
      rdata_p1   <= '0;
      success_p1 <= 1'b0;
      fail_cnt_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && pick_vld) begin
        last_grant <= pick_idx;
        op_p0      <= op[pick_idx] ? OP_CLAIM : OP_READ;
      end
      // Check (p1): result is held until the next transaction's check.
      if (state == S_CHECK) begin
        rdata_p1   <= mem_dout;
        success_p1 <= claim_ok;
        if (op_p0 == OP_CLAIM && !claim_ok) fail_cnt_q <= sat_inc16(fail_cnt_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && pick_vld) begin
      addr_p0  <= addr[pick_idx*ADDR_W +: ADDR_W];
      wdata_p0 <= wdata[pick_idx*DATA_W +: DATA_W];
    end
  end

  assign rdata    = rdata_p1;
  assign success  = success_p1;
  assign fail_cnt = fail_cnt_q;
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_grid_claim_arbiter.sv
// Randomised and directed bench for grid_claim_arbiter against a
// transaction-level model of the grid and the round-robin grant order.
module tb_grid_claim_arbiter;

  localparam int N = 4;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam logic [31:0] EMPTY = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req, op, ack;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [DW-1:0] rdata, mem_din, mem_dout;
  logic          success, mem_re, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [15:0]   fail_cnt;

  logic [DW-1:0] mem [0:4095];
  logic [DW-1:0] ref_mem [0:4095];
  int            wr_seen = 0;
  int            ack_seen = 0;

  logic [AW-1:0] b_addr [N];
  logic [DW-1:0] b_wd [N];
  logic          b_op [N];
  int            m_last;
  logic [15:0]   m_fail;
  logic [DW-1:0] m_rdata;
  int            n_checks = 0;
  int            n_err = 0;

  grid_claim_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .success(success), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy),
    .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] <= (i == 4) ? 32'd2 : EMPTY;
  end

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    if (mem_re) mem_dout <= mem[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_we) wr_seen <= wr_seen + 1;
    if (ack != '0) ack_seen <= ack_seen + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives the requesters in mask, then follows each granted transaction to its ack.
  task automatic run_batch(input logic [N-1:0] mask, input logic early);
    logic [N-1:0]  pend;
    logic [DW-1:0] cur;
    logic          exp_succ;
    int            k, cyc, w0;
    logic          first;
    pend = mask;
    first = 1'b1;
    for (int i = 0; i < N; i++) begin
      op[i] = b_op[i];
      addr[i*AW +: AW] = b_addr[i];
      wdata[i*DW +: DW] = b_wd[i];
    end
    req = mask;
    while (pend != '0) begin
      k = -1;
      for (int i = 1; i <= N; i++)
        if (k < 0 && pend[(m_last + i) % N]) k = (m_last + i) % N;
      m_last = k;
      cur = ref_mem[b_addr[k]];
      exp_succ = b_op[k] && (cur == EMPTY) && (b_wd[k] != EMPTY);
      if (exp_succ) ref_mem[b_addr[k]] = b_wd[k];
      else if (b_op[k]) m_fail = (m_fail == 16'hFFFF) ? m_fail : m_fail + 16'd1;
      m_rdata = cur;
      w0 = wr_seen;
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
        chk("re_we_excl", {63'd0, mem_re & mem_we}, 64'd0);
        if (early && cyc == (first ? 1 : 2)) req[k] = 1'b0;
      end while (ack == '0 && cyc < 12);
      chk("latency", cyc, first ? 4 : 5);
      chk("ack", ack, 64'(4'b0001 << k));
      chk("rdata", rdata, cur);
      chk("success", success, exp_succ);
      chk("fail_cnt", fail_cnt, m_fail);
      chk("writes", wr_seen - w0, exp_succ ? 1 : 0);
      chk("busy_resp", busy, 1);
      req[k] = 1'b0;
      pend[k] = 1'b0;
      first = 1'b0;
    end
    @(negedge clk);
    chk("hold_rdata", rdata, m_rdata);
    chk("idle_busy", busy, 0);
  endtask

  task automatic set_req(input int k, input logic o, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    b_op[k] = o;
    b_addr[k] = a;
    b_wd[k] = wd;
  endtask

  initial begin
    int a0, w0;
    reset = 1'b1;
    req = '0;
    op = '0;
    addr = '0;
    wdata = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = (i == 4) ? 32'd2 : EMPTY;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0);
    m_last = N - 1;
    m_fail = 16'd0;
    repeat (2) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_re_we", {mem_re, mem_we}, 0);
    chk("rst_addr_din", {mem_addr, mem_din}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_success", success, 0);
    chk("rst_fail", fail_cnt, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);

    set_req(0, 1'b1, 12'd5, 32'd3);
    run_batch(4'b0001, 1'b0);
    chk("cell5_claimed", mem[5], 3);
    set_req(1, 1'b1, 12'd5, 32'd7);
    run_batch(4'b0010, 1'b0);
    chk("cell5_kept", mem[5], 3);
    set_req(2, 1'b0, 12'd4, 32'd9);
    run_batch(4'b0100, 1'b0);
    set_req(3, 1'b0, 12'd4, 32'd0);
    run_batch(4'b1000, 1'b1);
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 12'd9, 32'(10 + i));
    run_batch(4'b1111, 1'b0);
    chk("cell9_owner", mem[9], 10);
    chk("cell4_read_only", mem[4], 2);

    // Reset in the CHECK cycle of a claim that would succeed.
    set_req(2, 1'b1, 12'd20, 32'd11);
    op[2] = 1'b1;
    addr[2*AW +: AW] = 12'd20;
    wdata[2*DW +: DW] = 32'd11;
    req = 4'b0100;
    a0 = ack_seen;
    w0 = wr_seen;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    chk("pre_rst_we", mem_we, 1);
    reset = 1'b1;
    #1;
    chk("rst_kill_we", mem_we, 0);
    chk("rst_kill_busy", busy, 0);
    chk("rst_kill_ack", ack, 0);
    req = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_no_write", wr_seen - w0, 0);
    chk("rst_no_ack", ack_seen - a0, 0);
    chk("cell20_free", mem[20], EMPTY);
    chk("rst_fail_clr", fail_cnt, 0);
    m_last = N - 1;
    m_fail = 16'd0;
    @(negedge clk);
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 12'd20, 32'd0);
    run_batch(4'b1111, 1'b0);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < N; i++)
        set_req(i, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 47)),
                ($urandom_range(0, 7) == 0) ? EMPTY : 32'($urandom_range(0, 255)));
      run_batch(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 48; i++) chk("cell_final", mem[i], ref_mem[i]);

    // Saturation of the failed-claim counter.
    force dut.fail_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.fail_cnt_q;
    @(negedge clk);
    chk("fail_forced", fail_cnt, 16'hFFFF);
    m_fail = 16'hFFFF;
    set_req(1, 1'b1, 12'd5, 32'd21);
    run_batch(4'b0010, 1'b0);
    set_req(3, 1'b1, 12'd30, EMPTY);
    run_batch(4'b1000, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
